// File: rtl/alu_issue_pkg.sv
// Shared encodings, FSM states and the one-hot select bundle for alu_issue_ctrl.
package alu_issue_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_SLTU  = 3'b011;
  localparam logic [2:0] F3_BEQ   = 3'b000;
  localparam logic [2:0] F3_BNE   = 3'b001;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_SUB   = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic sel_add;
    logic sel_sub;
    logic sel_and;
    logic sel_or;
    logic sel_slt;
  } alu_sel_t;

  localparam alu_sel_t SEL_NONE = 5'b00000;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of RISC-V fields into a one-hot ALU select.
// Branch decode (BEQ/BNE) exists only when ALU_BRANCH_EN is defined.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
`ifdef ALU_BRANCH_EN
  output logic       is_beq_o,
  output logic       is_bne_o,
`endif
  output alu_sel_t   sel_o,
  output logic       use_imm_o,
  output logic       illegal_o
);

  // Decode table; anything not matched stays illegal with no select.
  always_comb begin
    sel_o     = SEL_NONE;
    use_imm_o = 1'b0;
    illegal_o = 1'b1;
`ifdef ALU_BRANCH_EN
    is_beq_o  = 1'b0;
    is_bne_o  = 1'b0;
`endif
    case (opcode_i)
      OP_R: begin
        if (funct3_i == F3_ADD && funct7_i == F7_SUB) begin
          sel_o.sel_sub = 1'b1;
          illegal_o     = 1'b0;
        end else if (funct7_i == F7_BASE) begin
          case (funct3_i)
            F3_ADD:  begin sel_o.sel_add = 1'b1; illegal_o = 1'b0; end
            F3_AND:  begin sel_o.sel_and = 1'b1; illegal_o = 1'b0; end
            F3_OR:   begin sel_o.sel_or  = 1'b1; illegal_o = 1'b0; end
            F3_SLTU: begin sel_o.sel_slt = 1'b1; illegal_o = 1'b0; end
            default: illegal_o = 1'b1;
          endcase
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_I: begin
        use_imm_o = 1'b1;
        case (funct3_i)
          F3_ADD:  begin sel_o.sel_add = 1'b1; illegal_o = 1'b0; end
          F3_AND:  begin sel_o.sel_and = 1'b1; illegal_o = 1'b0; end
          F3_OR:   begin sel_o.sel_or  = 1'b1; illegal_o = 1'b0; end
          F3_SLTU: begin sel_o.sel_slt = 1'b1; illegal_o = 1'b0; end
          default: illegal_o = 1'b1;
        endcase
      end
`ifdef ALU_BRANCH_EN
      OP_BR: begin
        case (funct3_i)
          F3_BEQ:  begin sel_o.sel_sub = 1'b1; is_beq_o = 1'b1; illegal_o = 1'b0; end
          F3_BNE:  begin sel_o.sel_sub = 1'b1; is_bne_o = 1'b1; illegal_o = 1'b0; end
          default: illegal_o = 1'b1;
        endcase
      end
`endif
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a one-hot-select combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_BRANCH_EN to accept BEQ/BNE and drive out_taken.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             alu_sel_add,
  output logic             alu_sel_sub,
  output logic             alu_sel_and,
  output logic             alu_sel_or,
  output logic             alu_sel_slt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic             out_taken
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  alu_sel_t         sel_q, sel_d, dec_sel_s;
  logic             zero_q, zero_d, illegal_q, illegal_d;
  logic             dec_use_imm_s, dec_illegal_s;
`ifdef ALU_BRANCH_EN
  logic             dec_beq_s, dec_bne_s, beq_q, bne_q, taken_q;
`endif

  alu_issue_decode u_decode (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
`ifdef ALU_BRANCH_EN
    .is_beq_o  (dec_beq_s),
    .is_bne_o  (dec_bne_s),
`endif
    .sel_o     (dec_sel_s),
    .use_imm_o (dec_use_imm_s),
    .illegal_o (dec_illegal_s)
  );

  // Next-state: fields are sampled only on IDLE & in_valid; selects live only in EXEC.
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sel_d     = sel_q;
    illegal_d = illegal_q;
    res_d     = res_q;
    zero_d    = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_EXEC;
          opa_d     = rs1_data;
          opb_d     = dec_use_imm_s ? imm : rs2_data;
          sel_d     = dec_sel_s;
          illegal_d = dec_illegal_s;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        sel_d   = SEL_NONE;
        if (illegal_q) begin
          res_d  = '0;
          zero_d = 1'b1;
        end else begin
          res_d  = alu_result;
          zero_d = alu_zero;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      sel_q     <= SEL_NONE;
      illegal_q <= 1'b0;
      res_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sel_q     <= sel_d;
      illegal_q <= illegal_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
    end
  end

`ifdef ALU_BRANCH_EN
  // Branch kind rides with the op; the outcome is captured alongside the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beq_q   <= 1'b0;
      bne_q   <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && in_valid) begin
        beq_q <= dec_beq_s;
        bne_q <= dec_bne_s;
      end
      if (state_q == ST_EXEC) begin
        taken_q <= (beq_q & alu_zero) | (bne_q & ~alu_zero);
      end
    end
  end
  assign out_taken = taken_q;
`else
  assign out_taken = 1'b0;
`endif

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_RESP);
  assign operand_a   = opa_q;
  assign operand_b   = opb_q;
  assign alu_sel_add = sel_q.sel_add;
  assign alu_sel_sub = sel_q.sel_sub;
  assign alu_sel_and = sel_q.sel_and;
  assign alu_sel_or  = sel_q.sel_or;
  assign alu_sel_slt = sel_q.sel_slt;
  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU stand-in.
// Branch expectations follow ALU_BRANCH_EN.
module tb_alu_issue_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    opcode = 7'd0;
  logic [2:0]    funct3 = 3'd0;
  logic [6:0]    funct7 = 7'd0;
  logic [W-1:0]  rs1_data = 32'd0, rs2_data = 32'd0, imm = 32'd0;
  logic [W-1:0]  operand_a, operand_b;
  logic          alu_sel_add, alu_sel_sub, alu_sel_and, alu_sel_or, alu_sel_slt;
  logic [W-1:0]  alu_result;
  logic          alu_zero;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic          out_zero, out_illegal, out_taken;
  logic [4:0]    sel;

  int n_vec = 0;
  int n_bad = 0;

  alu_issue_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .operand_a(operand_a), .operand_b(operand_b),
    .alu_sel_add(alu_sel_add), .alu_sel_sub(alu_sel_sub), .alu_sel_and(alu_sel_and),
    .alu_sel_or(alu_sel_or), .alu_sel_slt(alu_sel_slt),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .out_taken(out_taken)
  );

  always #5 clk = ~clk;

  assign sel = {alu_sel_add, alu_sel_sub, alu_sel_and, alu_sel_or, alu_sel_slt};

  // Stand-in ALU; with no select it drives junk so illegal ops must override it.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    if (alu_sel_add)      alu_result = operand_a + operand_b;
    else if (alu_sel_sub) alu_result = operand_a - operand_b;
    else if (alu_sel_and) alu_result = operand_a & operand_b;
    else if (alu_sel_or)  alu_result = operand_a | operand_b;
    else if (alu_sel_slt) alu_result = (operand_a < operand_b) ? 32'd1 : 32'd0;
    else                  alu_result = 32'hDEAD_BEEF;
    alu_zero = (alu_result == 32'd0);
  end

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] im);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 20) begin
      n_vec++; n_bad++;
      $display("FAIL issue_wait in_ready: got %b need 1", in_ready);
    end
    opcode = op; funct3 = f3; funct7 = f7;
    rs1_data = a; rs2_data = b; imm = im; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 7'h7F; funct3 = 3'h7; funct7 = 7'h7F;
    rs1_data = 32'h1234_5678; rs2_data = 32'h8765_4321; imm = 32'h5555_AAAA;
  endtask

  task automatic release_resp();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #5;
    n_vec++;
    if ({in_ready, out_valid, out_result, out_zero, out_illegal, out_taken, sel, operand_a, operand_b}
        !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b res=%h zero=%b ill=%b taken=%b sel=%b a=%h b=%h need 1 0 0 0 0 0 0 0 0",
               in_ready, out_valid, out_result, out_zero, out_illegal, out_taken, sel, operand_a, operand_b);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    issue(7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd99);
    n_vec++;
    if (sel !== 5'b10000 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL add_exec: sel=%b valid=%b ready=%b need 10000 0 0", sel, out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, out_result, out_zero, out_illegal, sel} !== {1'b1, 32'd12, 1'b0, 1'b0, 5'd0}) begin
      n_bad++;
      $display("FAIL add_resp: valid=%b res=%0d zero=%b ill=%b sel=%b need 1 12 0 0 00000",
               out_valid, out_result, out_zero, out_illegal, sel);
    end
    release_resp();
  endtask

  task automatic test_sub_hold();
    issue(7'b0110011, 3'b000, 7'b0100000, 32'h10, 32'h10, 32'd0);
    n_vec++;
    if (sel !== 5'b01000) begin
      n_bad++;
      $display("FAIL sub_exec sel: got %b need 01000", sel);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({out_valid, in_ready, out_result, out_zero, out_illegal} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL sub_hold cycle %0d: valid=%b ready=%b res=%h zero=%b ill=%b need 1 0 0 1 0",
                 i, out_valid, in_ready, out_result, out_zero, out_illegal);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL no_passthrough in_ready: got %b need 0", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL sub_release: valid=%b ready=%b need 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_imm_ops();
    issue(7'b0010011, 3'b011, 7'b1111111, 32'd3, 32'd0, 32'hFFFF_FFFF);
    n_vec++;
    if (sel !== 5'b00001 || operand_b !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL sltiu_exec: sel=%b b=%h need 00001 ffffffff", sel, operand_b);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_result !== 32'd1 || out_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL sltiu_result: res=%h zero=%b need 1 0", out_result, out_zero);
    end
    release_resp();
    issue(7'b0010011, 3'b111, 7'b0000000, 32'h0000_F0F0, 32'hFFFF_FFFF, 32'h0000_0FF0);
    @(posedge clk); #1;
    n_vec++;
    if (out_result !== 32'h0000_00F0 || out_illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL andi_result: res=%h ill=%b need 000000f0 0", out_result, out_illegal);
    end
    release_resp();
  endtask

  task automatic test_illegal();
    issue(7'b0110111, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'd3);
    n_vec++;
    if (sel !== 5'b00000) begin
      n_bad++;
      $display("FAIL lui_sel: got %b need 00000", sel);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({out_illegal, out_result, out_zero, out_taken} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL lui_resp: ill=%b res=%h zero=%b taken=%b need 1 0 1 0", out_illegal, out_result, out_zero, out_taken);
    end
    release_resp();
    issue(7'b0110011, 3'b010, 7'b0000000, 32'd1, 32'd2, 32'd0);
    n_vec++;
    if (sel !== 5'b00000) begin
      n_bad++;
      $display("FAIL slt_signed_sel: got %b need 00000", sel);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({out_illegal, out_result, out_zero} !== {1'b1, 32'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL slt_signed_resp: ill=%b res=%h zero=%b need 1 0 1", out_illegal, out_result, out_zero);
    end
    release_resp();
  endtask

  task automatic test_reset_mid_op();
    issue(7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0);
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sel !== 5'b00000) begin
      n_bad++;
      $display("FAIL rst_exec: valid=%b ready=%b sel=%b need 0 1 00000", out_valid, in_ready, sel);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    issue(7'b0110011, 3'b000, 7'b0000000, 32'd2, 32'd2, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_resp: valid=%b ready=%b res=%h need 0 1 0", out_valid, in_ready, out_result);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    issue(7'b0110011, 3'b110, 7'b0000000, 32'hA, 32'h5, 32'd0);
    n_vec++;
    if (out_valid !== 1'b0 || sel !== 5'b00010) begin
      n_bad++;
      $display("FAIL or_exec: valid=%b sel=%b need 0 00010", out_valid, sel);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_result !== 32'hF) begin
      n_bad++;
      $display("FAIL or_resp: valid=%b res=%h need 1 f", out_valid, out_result);
    end
    release_resp();
  endtask

  task automatic test_branch();
    logic exp_ill;
    logic [W-1:0] exp_res;
`ifdef ALU_BRANCH_EN
    exp_ill = 1'b0; exp_res = 32'd0;
`else
    exp_ill = 1'b1; exp_res = 32'd0;
`endif
    issue(7'b1100011, 3'b000, 7'b0000000, 32'd9, 32'd9, 32'd0);
    @(posedge clk); #1;
    n_vec++;
`ifdef ALU_BRANCH_EN
    if (out_taken !== 1'b1 || out_illegal !== exp_ill || out_result !== exp_res) begin
`else
    if (out_taken !== 1'b0 || out_illegal !== exp_ill || out_result !== exp_res) begin
`endif
      n_bad++;
      $display("FAIL beq_resp: taken=%b ill=%b res=%h need ill=%b res=%h", out_taken, out_illegal, out_result, exp_ill, exp_res);
    end
    release_resp();
    issue(7'b1100011, 3'b001, 7'b0000000, 32'd9, 32'd9, 32'd0);
    @(posedge clk); #1;
    n_vec++;
    if (out_taken !== 1'b0 || out_illegal !== exp_ill || out_zero !== 1'b1) begin
      n_bad++;
      $display("FAIL bne_resp: taken=%b ill=%b zero=%b need 0 %b 1", out_taken, out_illegal, out_zero, exp_ill);
    end
    release_resp();
  endtask

  task automatic test_back_to_back();
    logic [8:0] seen;
    seen = 9'd0;
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
    rs1_data = 32'd20; rs2_data = 32'd22;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      seen[i] = out_valid;
      if (out_valid === 1'b1) begin
        n_vec++;
        if (out_result !== 32'd42 || in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_result cycle %0d: res=%0d ready=%b need 42 0", i, out_result, in_ready);
        end
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (seen !== 9'b010010010) begin
      n_bad++;
      $display("FAIL b2b_pattern: got %b need 010010010", seen);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_hold();
    test_imm_ops();
    test_illegal();
    test_reset_mid_op();
    test_branch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
